// File: rtl/rs_age_pkg.sv
// Shared defaults and types for the age-ordered reservation station (rs_age).
package rs_age_pkg;

  localparam int RS_AGE_ENTRIES   = 16;
  localparam int RS_AGE_DISP_W    = 3;
  localparam int RS_AGE_ISSUE_W   = 2;
  localparam int RS_AGE_CDB_W     = 3;
  localparam int RS_AGE_TAG_W     = 6;
  localparam int RS_AGE_BMASK_W   = 4;
  localparam int RS_AGE_PAYLOAD_W = 32;

  typedef logic [$clog2(RS_AGE_ENTRIES)-1:0] rs_age_idx_t;

  typedef struct packed {
    logic                          valid;
    logic [RS_AGE_TAG_W-1:0]       t_new;
    logic [RS_AGE_TAG_W-1:0]       src1;
    logic [RS_AGE_TAG_W-1:0]       src2;
    logic                          rdy1;
    logic                          rdy2;
    logic [RS_AGE_BMASK_W-1:0]     bmask;
    logic [RS_AGE_PAYLOAD_W-1:0]   payload;
  } rs_age_entry_t;

endpackage

// File: rtl/rs_age_pick.sv
// Oldest-first picker: returns the one-hot eligible entry that is older than every other eligible entry.
module rs_age_pick
  import rs_age_pkg::*;
#(
  parameter int ENTRIES = RS_AGE_ENTRIES
) (
  input  logic [ENTRIES-1:0]              elig,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
  output logic [ENTRIES-1:0]              pick
);

  always_comb begin
    pick = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pick[i] = elig[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && elig[j] && !age[i][j]) pick[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_age.sv
// Age-ordered reservation station: wakes entries from the CDB and issues the oldest ready ones itself.
// Optional macro RS_WAKEUP_BYPASS_EN: a CDB match makes a resident entry selectable in the same cycle.
module rs_age
  import rs_age_pkg::*;
#(
  parameter int ENTRIES   = RS_AGE_ENTRIES,
  parameter int DISP_W    = RS_AGE_DISP_W,
  parameter int ISSUE_W   = RS_AGE_ISSUE_W,
  parameter int CDB_W     = RS_AGE_CDB_W,
  parameter int TAG_W     = RS_AGE_TAG_W,
  parameter int BMASK_W   = RS_AGE_BMASK_W,
  parameter int PAYLOAD_W = RS_AGE_PAYLOAD_W
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DISP_W-1:0]                     disp_valid,
  input  logic [DISP_W-1:0][TAG_W-1:0]          disp_t_new,
  input  logic [DISP_W-1:0][TAG_W-1:0]          disp_src1,
  input  logic [DISP_W-1:0][TAG_W-1:0]          disp_src2,
  input  logic [DISP_W-1:0]                     disp_src1_rdy,
  input  logic [DISP_W-1:0]                     disp_src2_rdy,
  input  logic [DISP_W-1:0][BMASK_W-1:0]        disp_bmask,
  input  logic [DISP_W-1:0][PAYLOAD_W-1:0]      disp_payload,
  output logic [$clog2(ENTRIES+1)-1:0]          free_count,
  input  logic [CDB_W-1:0]                      cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]           cdb_tag,
  input  logic [ISSUE_W-1:0]                    fu_ready,
  output logic [ISSUE_W-1:0]                    iss_valid,
  output logic [ISSUE_W-1:0][TAG_W-1:0]         iss_t_new,
  output logic [ISSUE_W-1:0][TAG_W-1:0]         iss_src1,
  output logic [ISSUE_W-1:0][TAG_W-1:0]         iss_src2,
  output logic [ISSUE_W-1:0][BMASK_W-1:0]       iss_bmask,
  output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]     iss_payload,
  input  logic                                  br_valid,
  input  logic [BMASK_W-1:0]                    br_mask,
  input  logic                                  br_mispred
);

  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]     t_new;
    logic [TAG_W-1:0]     src1;
    logic [TAG_W-1:0]     src2;
    logic                 rdy1;
    logic                 rdy2;
    logic [BMASK_W-1:0]   bmask;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [CDB_W-1:0] vld,
                                   input logic [CDB_W-1:0][TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (vld[c] && tags[c] == tag) cdb_hit = 1'b1;
    end
  endfunction

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;
  logic [CNT_W-1:0]                free_count_q, free_count_d;
  entry_t                          ent_q [ENTRIES];
  entry_t                          ent_d [ENTRIES];

  logic [ENTRIES-1:0]              rdy1_w, rdy2_w, squash, elig;
  logic [ISSUE_W-1:0][ENTRIES-1:0] taken, pick, grant, iss_grant;
  logic [DISP_W-1:0]               lane_wr;
  logic [DISP_W-1:0][IDX_W-1:0]    lane_slot;
  logic [ENTRIES-1:0]              alloc_mask;
  logic                            mispred;
  logic [BMASK_W-1:0]              keep_mask;

  assign mispred   = br_valid && br_mispred;
  assign keep_mask = (br_valid && !br_mispred) ? ~br_mask : '1;

  always_comb begin
    rdy1_w = '0;
    rdy2_w = '0;
    squash = '0;
    elig   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rdy1_w[i] = ent_q[i].rdy1 | cdb_hit(ent_q[i].src1, cdb_valid, cdb_tag);
      rdy2_w[i] = ent_q[i].rdy2 | cdb_hit(ent_q[i].src2, cdb_valid, cdb_tag);
      squash[i] = valid_q[i] && mispred && |(ent_q[i].bmask & br_mask);
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i]   = valid_q[i] && rdy1_w[i] && rdy2_w[i];
`else
      elig[i]   = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
    end
  end

  // Squashed picks still occupy their port so younger entries never backfill it.
  for (genvar k = 0; k < ISSUE_W; k++) begin : g_port
    if (k == 0) begin : g_first
      assign taken[k] = '0;
    end else begin : g_rest
      assign taken[k] = taken[k-1] | grant[k-1];
    end
    rs_age_pick #(.ENTRIES(ENTRIES)) u_pick (
      .elig (elig & ~taken[k]),
      .age  (age_q),
      .pick (pick[k])
    );
    assign grant[k]     = pick[k] & {ENTRIES{fu_ready[k]}};
    assign iss_grant[k] = grant[k] & ~squash;
    assign iss_valid[k] = |iss_grant[k];
  end

  always_comb begin
    iss_t_new   = '0;
    iss_src1    = '0;
    iss_src2    = '0;
    iss_bmask   = '0;
    iss_payload = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (iss_grant[k][i]) begin
          iss_t_new[k]   = ent_q[i].t_new;
          iss_src1[k]    = ent_q[i].src1;
          iss_src2[k]    = ent_q[i].src2;
          iss_bmask[k]   = ent_q[i].bmask;
          iss_payload[k] = ent_q[i].payload;
        end
      end
    end
  end

  // Accepted lanes take the lowest pre-edge free slots in lane order.
  always_comb begin
    logic lane_ok;
    alloc_mask = '0;
    lane_wr    = '0;
    lane_slot  = '0;
    lane_ok    = 1'b0;
    for (int l = 0; l < DISP_W; l++) begin
      lane_ok = disp_valid[l] && !(mispred && |(disp_bmask[l] & br_mask));
      if (lane_ok) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (!lane_wr[l] && !valid_q[i] && !alloc_mask[i]) begin
            lane_wr[l]    = 1'b1;
            lane_slot[l]  = IDX_W'(i);
            alloc_mask[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic [ENTRIES-1:0] issued;
    valid_d = valid_q;
    age_d   = age_q;
    issued  = '0;
    for (int i = 0; i < ENTRIES; i++) ent_d[i] = ent_q[i];
    for (int k = 0; k < ISSUE_W; k++) issued = issued | iss_grant[k];

    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i]) begin
        ent_d[i].rdy1  = rdy1_w[i];
        ent_d[i].rdy2  = rdy2_w[i];
        ent_d[i].bmask = ent_q[i].bmask & keep_mask;
        if (squash[i] || issued[i]) valid_d[i] = 1'b0;
      end
    end

    for (int l = 0; l < DISP_W; l++) begin
      if (lane_wr[l]) begin
        valid_d[lane_slot[l]]         = 1'b1;
        ent_d[lane_slot[l]].t_new     = disp_t_new[l];
        ent_d[lane_slot[l]].src1      = disp_src1[l];
        ent_d[lane_slot[l]].src2      = disp_src2[l];
        ent_d[lane_slot[l]].rdy1      = disp_src1_rdy[l] | cdb_hit(disp_src1[l], cdb_valid, cdb_tag);
        ent_d[lane_slot[l]].rdy2      = disp_src2_rdy[l] | cdb_hit(disp_src2[l], cdb_valid, cdb_tag);
        ent_d[lane_slot[l]].bmask     = disp_bmask[l] & keep_mask;
        ent_d[lane_slot[l]].payload   = disp_payload[l];
        for (int j = 0; j < ENTRIES; j++) begin
          age_d[lane_slot[l]][j] = 1'b0;
          age_d[j][lane_slot[l]] = valid_q[j];
        end
      end
    end

    // Lower lanes of one dispatch group are older than higher lanes.
    for (int a = 0; a < DISP_W; a++) begin
      for (int b = a + 1; b < DISP_W; b++) begin
        if (lane_wr[a] && lane_wr[b]) begin
          age_d[lane_slot[a]][lane_slot[b]] = 1'b1;
          age_d[lane_slot[b]][lane_slot[a]] = 1'b0;
        end
      end
    end

    free_count_d = CNT_W'(ENTRIES - $countones(valid_d));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      age_q        <= '0;
      free_count_q <= CNT_W'(ENTRIES);
    end else begin
      valid_q      <= valid_d;
      age_q        <= age_d;
      free_count_q <= free_count_d;
    end
  end

  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  assign free_count = free_count_q;

  disp_capacity_a: assert property (@(posedge clock) disable iff (reset)
    $countones(disp_valid) <= int'(free_count_q));

  disp_contiguous_a: assert property (@(posedge clock) disable iff (reset)
    (disp_valid & (disp_valid + DISP_W'(1))) == '0);

endmodule

// File: tb/tb_rs_age.sv
// Bench for rs_age: directed scenarios plus random traffic against a sequence-number reference model.
module tb_rs_age;

  localparam int ENT = 16;
  localparam int DW  = 3;
  localparam int IW  = 2;
  localparam int CW  = 3;
  localparam int TW  = 6;
  localparam int BW  = 4;
  localparam int PW  = 32;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [DW-1:0]            disp_valid;
  logic [DW-1:0][TW-1:0]    disp_t_new, disp_src1, disp_src2;
  logic [DW-1:0]            disp_src1_rdy, disp_src2_rdy;
  logic [DW-1:0][BW-1:0]    disp_bmask;
  logic [DW-1:0][PW-1:0]    disp_payload;
  logic [$clog2(ENT+1)-1:0] free_count;
  logic [CW-1:0]            cdb_valid;
  logic [CW-1:0][TW-1:0]    cdb_tag;
  logic [IW-1:0]            fu_ready;
  logic [IW-1:0]            iss_valid;
  logic [IW-1:0][TW-1:0]    iss_t_new, iss_src1, iss_src2;
  logic [IW-1:0][BW-1:0]    iss_bmask;
  logic [IW-1:0][PW-1:0]    iss_payload;
  logic                     br_valid;
  logic [BW-1:0]            br_mask;
  logic                     br_mispred;

  rs_age #(.ENTRIES(ENT), .DISP_W(DW), .ISSUE_W(IW), .CDB_W(CW), .TAG_W(TW),
           .BMASK_W(BW), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_t_new(disp_t_new), .disp_src1(disp_src1),
    .disp_src2(disp_src2), .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_bmask(disp_bmask), .disp_payload(disp_payload), .free_count(free_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_t_new(iss_t_new), .iss_src1(iss_src1),
    .iss_src2(iss_src2), .iss_bmask(iss_bmask), .iss_payload(iss_payload),
    .br_valid(br_valid), .br_mask(br_mask), .br_mispred(br_mispred)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each resident op carries a dispatch sequence number; lower = older.
  bit            m_v  [ENT];
  logic [TW-1:0] m_t  [ENT];
  logic [TW-1:0] m_s1 [ENT];
  logic [TW-1:0] m_s2 [ENT];
  bit            m_r1 [ENT];
  bit            m_r2 [ENT];
  logic [BW-1:0] m_bm [ENT];
  logic [PW-1:0] m_pl [ENT];
  int            m_seq[ENT];
  int            next_seq = 0;

  function automatic bit cdb_match(input logic [TW-1:0] t);
    for (int c = 0; c < CW; c++) if (cdb_valid[c] && cdb_tag[c] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_used();
    int n = 0;
    for (int i = 0; i < ENT; i++) if (m_v[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENT; i++) m_v[i] = 1'b0;
  endtask

  task automatic idle();
    disp_valid = '0; disp_t_new = '0; disp_src1 = '0; disp_src2 = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_bmask = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0; fu_ready = '1;
    br_valid = 1'b0; br_mask = '0; br_mispred = 1'b0;
  endtask

  task automatic lane(input int l, input logic [TW-1:0] tn, input logic [TW-1:0] s1,
                      input logic [TW-1:0] s2, input bit r1, input bit r2,
                      input logic [BW-1:0] bm, input logic [PW-1:0] pl);
    disp_valid[l] = 1'b1; disp_t_new[l] = tn; disp_src1[l] = s1; disp_src2[l] = s2;
    disp_src1_rdy[l] = r1; disp_src2_rdy[l] = r2; disp_bmask[l] = bm; disp_payload[l] = pl;
  endtask

  // Called at a negedge with inputs applied; checks outputs, advances the model, returns at the next negedge.
  task automatic step();
    bit sq[ENT]; bit el[ENT]; bit took[ENT]; bit prefree[ENT];
    bit mis, ev, ok, r1, r2; int p; logic [BW-1:0] keep;
    #1;
    mis  = br_valid && br_mispred;
    keep = (br_valid && !br_mispred) ? ~br_mask : '1;
    check("free_count", 64'(free_count), 64'(ENT - model_used()));
    for (int i = 0; i < ENT; i++) begin
      sq[i] = m_v[i] && mis && ((m_bm[i] & br_mask) != 0);
`ifdef RS_WAKEUP_BYPASS_EN
      el[i] = m_v[i] && (m_r1[i] || cdb_match(m_s1[i])) && (m_r2[i] || cdb_match(m_s2[i]));
`else
      el[i] = m_v[i] && m_r1[i] && m_r2[i];
`endif
      took[i] = 1'b0;
    end
    for (int k = 0; k < IW; k++) begin
      p = -1; ev = 1'b0;
      if (fu_ready[k]) begin
        for (int i = 0; i < ENT; i++)
          if (el[i] && !took[i] && (p < 0 || m_seq[i] < m_seq[p])) p = i;
        if (p >= 0) begin took[p] = 1'b1; ev = !sq[p]; end
      end
      check($sformatf("iss_valid[%0d]", k), 64'(iss_valid[k]), 64'(ev));
      if (ev) begin
        check($sformatf("iss_t_new[%0d]", k), 64'(iss_t_new[k]), 64'(m_t[p]));
        check($sformatf("iss_srcs[%0d]", k), 64'({iss_src1[k], iss_src2[k]}), 64'({m_s1[p], m_s2[p]}));
        check($sformatf("iss_bmask[%0d]", k), 64'(iss_bmask[k]), 64'(m_bm[p]));
        check($sformatf("iss_payload[%0d]", k), 64'(iss_payload[k]), 64'(m_pl[p]));
      end
    end
    for (int i = 0; i < ENT; i++) begin
      prefree[i] = !m_v[i];
      if (m_v[i]) begin
        if (took[i] || sq[i]) m_v[i] = 1'b0;
        m_r1[i] = m_r1[i] || cdb_match(m_s1[i]);
        m_r2[i] = m_r2[i] || cdb_match(m_s2[i]);
        m_bm[i] = m_bm[i] & keep;
      end
    end
    for (int l = 0; l < DW; l++) begin
      ok = disp_valid[l] && !(mis && ((disp_bmask[l] & br_mask) != 0));
      r1 = disp_src1_rdy[l] || cdb_match(disp_src1[l]);
      r2 = disp_src2_rdy[l] || cdb_match(disp_src2[l]);
      for (int i = 0; i < ENT; i++) begin
        if (ok && prefree[i]) begin
          prefree[i] = 1'b0; ok = 1'b0;
          m_v[i] = 1'b1; m_t[i] = disp_t_new[l]; m_s1[i] = disp_src1[l]; m_s2[i] = disp_src2[l];
          m_r1[i] = r1; m_r2[i] = r2; m_bm[i] = disp_bmask[l] & keep; m_pl[i] = disp_payload[l];
          m_seq[i] = next_seq; next_seq++;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic branch_scenario(input bit mp);
    idle();
    lane(0, 6'd1, 6'd0, 6'd0, 1'b1, 1'b1, 4'b0001, 32'd400);
    lane(1, 6'd2, 6'd0, 6'd0, 1'b1, 1'b1, 4'b0010, 32'd401);
    lane(2, 6'd3, 6'd40, 6'd0, 1'b0, 1'b1, 4'b0001, 32'd402);
    step();
    idle();
    fu_ready = 2'b01; br_valid = 1'b1; br_mask = 4'b0001; br_mispred = mp;
    lane(0, 6'd4, 6'd40, 6'd0, 1'b0, 1'b1, 4'b0001, 32'd403);
    lane(1, 6'd5, 6'd40, 6'd0, 1'b0, 1'b1, 4'b0100, 32'd404);
    step();
    idle(); step(); step();
    cdb_valid[2] = 1'b1; cdb_tag[2] = 6'd40;
    step();
    idle();
    repeat (4) step();
  endtask

  initial begin
    int n, nd, room;
    idle();
    model_clear();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("reset_iss_valid", 64'(iss_valid), 64'(0));
    check("reset_free_count", 64'(free_count), 64'(ENT));
    check("reset_iss_payload", 64'(iss_payload), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Three ready lanes: two issue, then one, free count 16->13->15->16.
    idle();
    for (int l = 0; l < 3; l++) lane(l, 6'(10 + l), 6'd1, 6'd2, 1'b1, 1'b1, 4'b0000, 32'(100 + l));
    step();
    idle();
    repeat (3) step();

    // Late source woken by CDB channel 1.
    lane(0, 6'd10, 6'd5, 6'd6, 1'b0, 1'b1, 4'b0000, 32'd200);
    step();
    idle(); step();
    cdb_valid[1] = 1'b1; cdb_tag[1] = 6'd5;
    step();
    idle(); step(); step();

    // Fill all 16 slots unready; tag 7 wakes the 4th and 10th op.
    n = 0;
    for (int g = 0; g < 6; g++) begin
      idle();
      for (int l = 0; l < 3; l++) begin
        if (n < ENT) begin
          lane(l, 6'(n), (n == 3 || n == 9) ? 6'd7 : 6'd30, 6'd1, 1'b0, 1'b1, 4'b0000, 32'(300 + n));
          n++;
        end
      end
      step();
    end
    idle();
    #1;
    check("full_free_count", 64'(free_count), 64'(0));
    check("full_iss_valid", 64'(iss_valid), 64'(0));
    step();
    cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd7; fu_ready = 2'b01;
    step();
    idle(); fu_ready = 2'b01;
    step(); step();
    idle();
    cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd30;
    step();
    idle();
    repeat (10) step();

    branch_scenario(1'b1);
    branch_scenario(1'b0);

    // Reset while five ops are resident and one of them is issuing.
    idle();
    for (int l = 0; l < 3; l++) lane(l, 6'(20 + l), 6'd50, 6'd0, 1'b0, 1'b1, 4'b0000, 32'(500 + l));
    step();
    idle();
    lane(0, 6'd23, 6'd0, 6'd0, 1'b1, 1'b1, 4'b0000, 32'd503);
    lane(1, 6'd24, 6'd50, 6'd0, 1'b0, 1'b1, 4'b0000, 32'd504);
    step();
    idle();
    #1;
    check("pre_reset_iss_valid", 64'(iss_valid[0]), 64'(1));
    reset = 1'b1;
    #1;
    check("mid_reset_iss_valid", 64'(iss_valid), 64'(0));
    check("mid_reset_free_count", 64'(free_count), 64'(ENT));
    model_clear();
    @(negedge clock);
    reset = 1'b0;

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      room = ENT - model_used();
      nd = $urandom_range(0, (room < DW) ? room : DW);
      for (int l = 0; l < nd; l++)
        lane(l, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom & $urandom), $urandom);
      cdb_valid = 3'($urandom_range(0, 7));
      for (int c = 0; c < CW; c++) cdb_tag[c] = 6'($urandom_range(0, 15));
      fu_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        br_valid = 1'b1;
        br_mask = 4'(1 << $urandom_range(0, 3));
        br_mispred = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_age.md
Name: rs_age

Overview:
- Parametrised reservation station that succeeds the fixed-size rs.
- Holds dispatched micro-ops until both sources are ready, then issues them internally, oldest first, on up to ISSUE_W ports per cycle.
- Tracks branch masks for resolve/squash and snoops CDB_W result-broadcast channels.
- Sits between dispatch and the functional units. Unlike rs, the issue stage no longer chooses which entries issue; rs_age selects them itself.

Parameters:
- ENTRIES, 16, number of RS slots (≥2).
- DISP_W, 3, dispatch lanes per cycle.
- ISSUE_W, 2, issue ports per cycle.
- CDB_W, 3, CDB broadcast channels.
- TAG_W, 6, physical register tag width.
- BMASK_W, 4, branch mask width.
- PAYLOAD_W, 32, opaque op payload (opcode, immediates, etc.).

Ports:
- Clock and reset:
  - clock  in  1  system clock.
  - reset  in  1  asynchronous, active-high reset.
- Dispatch (arrays indexed by lane, [DISP_W]):
  - disp_valid  in  [DISP_W]  lane valid; set lanes must be contiguous from lane 0.
  - disp_t_new  in  [DISP_W][TAG_W]  destination tag.
  - disp_src1, disp_src2  in  [DISP_W][TAG_W]  source tags.
  - disp_src1_rdy, disp_src2_rdy  in  [DISP_W]  source already ready.
  - disp_bmask  in  [DISP_W][BMASK_W]  branch dependencies.
  - disp_payload  in  [DISP_W][PAYLOAD_W]  opaque payload.
  - free_count  out  $clog2(ENTRIES+1)  number of empty slots; registered.
- CDB:
  - cdb_valid  in  [CDB_W]  channel valid.
  - cdb_tag  in  [CDB_W][TAG_W]  broadcast tag.
- Issue (arrays indexed by port, [ISSUE_W]):
  - fu_ready  in  [ISSUE_W]  port k may accept an op this cycle.
  - iss_valid  out  [ISSUE_W]  port k carries an op.
  - iss_t_new, iss_src1, iss_src2, iss_bmask, iss_payload  out  per port  fields of the issued entry.
- Branch resolution:
  - br_valid  in  1  a branch resolves this cycle.
  - br_mask  in  BMASK_W  one-hot bit of the resolving branch.
  - br_mispred  in  1  the resolving branch was mispredicted.

Behaviour:
- Reset: all entries invalid; age matrix cleared; free_count=ENTRIES; iss_valid=0. All other outputs are 0 during reset. Asserting reset mid-operation discards every entry immediately.
- Dispatch:
  - popcount(disp_valid) must be ≤ free_count; violating this is an SVA error.
  - Lanes fill the lowest-index free slots in lane order.
  - Written entries are valid at the next edge and become issue-eligible the cycle after they are written.
  - A source whose tag matches a valid cdb_tag in the dispatch cycle is captured as ready.
  - Incoming disp_bmask is ANDed with ~br_mask when br_valid && !br_mispred.
  - On br_valid && br_mispred, lanes whose bmask hits br_mask are dropped and not written.
- Wakeup: any valid entry source matching a valid cdb_tag sets its ready bit at the edge.
- Age tracking:
  - Age matrix: bit [i][j]=1 means entry i is older than entry j.
  - Within one dispatch group, lane 0 is the oldest.
- Select:
  - Port k receives the oldest ready entry not already chosen by ports 0..k-1, only if fu_ready[k]=1.
  - If fu_ready[k]=0, iss_valid[k]=0 and no entry is consumed for that port.
  - Issue is combinational from state; the issued entry is freed at the edge.
- Branch resolve:
  - br_valid && !br_mispred: clear the br_mask bit in every entry.
  - br_valid && br_mispred: invalidate every entry whose bmask hits br_mask. Such entries also have iss_valid forced to 0 in that cycle, and ports are not backfilled with younger entries.
- free_count: next value = current − accepted dispatches + issued + squashed.
- Simultaneous events:
  - An issued entry being freed and a dispatch into the same slot in one cycle cannot collide, because dispatch uses pre-edge free slots.
  - CDB wakeup and squash of the same entry: squash wins.
- Full RS: free_count=0, dispatch must be 0. Empty RS: iss_valid=0.

Optional Feature:
- RS_WAKEUP_BYPASS_EN
  - Defined: a CDB tag match this cycle makes a resident entry selectable in the same cycle (0-cycle wakeup-to-issue).
  - Undefined: a woken entry is selectable from the next cycle.

Decomposition:
- sys_defs.svh gains:
  - RS_AGE_ENTRY struct (valid, t_new, src1/2, rdy1/2, bmask, payload).
  - RS_AGE_IDX typedef.
  - Defaults for DISP_W, ISSUE_W and CDB_W.
- Sub-module rs_age_pick: given an eligibility vector and the age matrix, returns the one-hot oldest entry. Instantiated ISSUE_W times with progressive masking.

Test Plan:
- Reset then dispatch 3 lanes with all sources ready, fu_ready=2'b11 → next cycle lanes 0 and 1 issue, lane 2 issues the following cycle; free_count goes 16→13→15→16.
- Dispatch an entry with src1=5 not ready; one cycle later cdb_valid[1]=1 with tag 5 → issues one cycle after the broadcast (same cycle if RS_WAKEUP_BYPASS_EN).
- Fill to 16 entries with none ready → free_count=0 and iss_valid=0; then broadcast tag 7 which readies entries 3 and 9 → the older of the two issues first.
- Entries with bmask 4'b0001 and 4'b0010 present; br_valid with br_mask=0001 and mispred=1 → only the 0001 entries vanish and are not issued; free_count rises accordingly.
- Same stimulus with mispred=0 → the 0001 bit is cleared in all entries and none are removed.
- Assert reset while 5 entries are resident and one is issuing → iss_valid=0 and free_count=16 immediately.
